// File: rtl/cnn_pkg.sv
// Shared types and the score-ordering rule for the CNN output stage.
package cnn_pkg;

    typedef enum logic {
        COLLECT = 1'b0,
        PEND    = 1'b1
    } coll_state_e;

    typedef struct packed {
        logic err_len;
        logic err_sop;
    } frame_status_t;

    localparam int SCORE_EXT_W = 64;

    // Scores arrive pre-extended to SCORE_EXT_W, so one compare serves every DATA_WIDTH.
    function automatic logic score_gt(
        input logic [SCORE_EXT_W-1:0] a,
        input logic [SCORE_EXT_W-1:0] b,
        input logic                   signed_mode,
        input logic                   tie_low
    );
        logic gt;
        if (signed_mode) begin
            gt = $signed(a) > $signed(b);
        end else begin
            gt = a > b;
        end
        return gt | ((a == b) & ~tie_low);
    endfunction

endpackage

// File: rtl/score_cmp.sv
// Combinational beat-vs-running-max decision used by the argmax collector.
module score_cmp
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int SIGNED     = 1,
    parameter int TIE_LOW    = 1
) (
    input  logic [DATA_WIDTH-1:0] beat_i,
    input  logic [DATA_WIDTH-1:0] max_i,
    output logic                  update_o
);

    logic [SCORE_EXT_W-1:0] beat_ext;
    logic [SCORE_EXT_W-1:0] max_ext;

    generate
        if (SIGNED != 0) begin : g_sext
            assign beat_ext = SCORE_EXT_W'($signed(beat_i));
            assign max_ext  = SCORE_EXT_W'($signed(max_i));
        end else begin : g_zext
            assign beat_ext = SCORE_EXT_W'(beat_i);
            assign max_ext  = SCORE_EXT_W'(max_i);
        end
    endgenerate

    assign update_o = score_gt(beat_ext, max_ext, SIGNED != 0, TIE_LOW != 0);

endmodule

// File: rtl/class_argmax_collector.sv
// Collects a sop/eop-framed stream of class scores, tracks argmax/max and
// presents each completed frame with integrity flags over valid/ready.
module class_argmax_collector
    import cnn_pkg::*;
#(
    parameter int DATA_WIDTH  = 32,
    parameter int CLASSES_QNT = 10,
    parameter int SIGNED      = 1,
    parameter int TIE_LOW     = 1,
    localparam int IDX_W      = (CLASSES_QNT > 1) ? $clog2(CLASSES_QNT) : 1
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              clk_en,
    input  logic [DATA_WIDTH-1:0]             i_data,
    input  logic                              i_valid,
    input  logic                              i_sop,
    input  logic                              i_eop,
    output logic                              i_ready,
    output logic                              o_valid,
    input  logic                              o_ready,
    output logic [CLASSES_QNT*DATA_WIDTH-1:0] o_classes,
    output logic [IDX_W-1:0]                  o_argmax,
    output logic [DATA_WIDTH-1:0]             o_max,
    output logic                              o_err_len,
    output logic                              o_err_sop
);

    localparam int CNT_W = $clog2(CLASSES_QNT + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLASSES_QNT);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(CLASSES_QNT + 1);

    coll_state_e            state_q, state_d;
    logic                   open_q, open_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]  slot_q [CLASSES_QNT];
    logic [DATA_WIDTH-1:0]  slot_d [CLASSES_QNT];
    logic [DATA_WIDTH-1:0]  max_q, max_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    frame_status_t          stat_q, stat_d;
    logic                   stray_q, stray_d;

    logic                   out_valid_q, out_valid_d;
    logic [DATA_WIDTH-1:0]  out_slot_q [CLASSES_QNT];
    logic [DATA_WIDTH-1:0]  out_slot_d [CLASSES_QNT];
    logic [DATA_WIDTH-1:0]  out_max_q, out_max_d;
    logic [IDX_W-1:0]       out_idx_q, out_idx_d;
    frame_status_t          out_stat_q, out_stat_d;

    logic beat_acc;
    logic res_acc;
    logic out_free;
    logic frame_done;
    logic update;

    assign i_ready  = (state_q == COLLECT);
    assign beat_acc = i_valid & i_ready & clk_en;
    assign res_acc  = out_valid_q & o_ready & clk_en;
    assign out_free = ~out_valid_q | res_acc;

    score_cmp #(
        .DATA_WIDTH (DATA_WIDTH),
        .SIGNED     (SIGNED),
        .TIE_LOW    (TIE_LOW)
    ) u_cmp (
        .beat_i   (i_data),
        .max_i    (max_q),
        .update_o (update)
    );

    // Frame accumulation: the _d values already include the current beat,
    // so an eop beat can be forwarded straight into the output register.
    always_comb begin
        open_d  = open_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        max_d   = max_q;
        idx_d   = idx_q;
        stat_d  = stat_q;
        stray_d = stray_q;
        if (beat_acc) begin
            if (i_sop) begin
                open_d = 1'b1;
                cnt_d  = CNT_W'(1);
                for (int s = 0; s < CLASSES_QNT; s++) begin
                    slot_d[s] = '0;
                end
                slot_d[0]      = i_data;
                max_d          = i_data;
                idx_d          = '0;
                stat_d.err_len = 1'b0;
                stat_d.err_sop = stray_q | open_q;
                stray_d        = 1'b0;
            end else if (open_q) begin
                if (cnt_q != CNT_SAT) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                if (cnt_q < CNT_FULL) begin
                    for (int s = 0; s < CLASSES_QNT; s++) begin
                        if (cnt_q == CNT_W'(s)) begin
                            slot_d[s] = i_data;
                        end
                    end
                    if (update) begin
                        max_d = i_data;
                        idx_d = IDX_W'(cnt_q);
                    end
                end
            end else begin
                stray_d = 1'b1;
            end
            if (i_eop & (i_sop | open_q)) begin
                open_d         = 1'b0;
                stat_d.err_len = (cnt_d != CNT_FULL);
            end
        end
    end

    assign frame_done = beat_acc & i_eop & (i_sop | open_q);

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_slot_d  = out_slot_q;
        out_max_d   = out_max_q;
        out_idx_d   = out_idx_q;
        out_stat_d  = out_stat_q;
        if (res_acc) begin
            out_valid_d = 1'b0;
        end
        case (state_q)
            COLLECT: begin
                if (frame_done) begin
                    if (out_free) begin
                        out_valid_d = 1'b1;
                        out_slot_d  = slot_d;
                        out_max_d   = max_d;
                        out_idx_d   = idx_d;
                        out_stat_d  = stat_d;
                    end else begin
                        state_d = PEND;
                    end
                end
            end
            PEND: begin
                // No beats are accepted here, so the frame registers still hold the finished frame.
                if (out_free) begin
                    out_valid_d = 1'b1;
                    out_slot_d  = slot_q;
                    out_max_d   = max_q;
                    out_idx_d   = idx_q;
                    out_stat_d  = stat_q;
                    state_d     = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= COLLECT;
            open_q      <= 1'b0;
            cnt_q       <= '0;
            max_q       <= '0;
            idx_q       <= '0;
            stat_q      <= '0;
            stray_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_max_q   <= '0;
            out_idx_q   <= '0;
            out_stat_q  <= '0;
            for (int s = 0; s < CLASSES_QNT; s++) begin
                slot_q[s]     <= '0;
                out_slot_q[s] <= '0;
            end
        end else if (clk_en) begin
            state_q     <= state_d;
            open_q      <= open_d;
            cnt_q       <= cnt_d;
            max_q       <= max_d;
            idx_q       <= idx_d;
            stat_q      <= stat_d;
            stray_q     <= stray_d;
            out_valid_q <= out_valid_d;
            out_max_q   <= out_max_d;
            out_idx_q   <= out_idx_d;
            out_stat_q  <= out_stat_d;
            for (int s = 0; s < CLASSES_QNT; s++) begin
                slot_q[s]     <= slot_d[s];
                out_slot_q[s] <= out_slot_d[s];
            end
        end
    end

    generate
        for (genvar gi = 0; gi < CLASSES_QNT; gi++) begin : g_pack
            assign o_classes[gi*DATA_WIDTH +: DATA_WIDTH] = out_slot_q[gi];
        end
    endgenerate

    assign o_valid   = out_valid_q;
    assign o_argmax  = out_idx_q;
    assign o_max     = out_max_q;
    assign o_err_len = out_stat_q.err_len;
    assign o_err_sop = out_stat_q.err_sop;

endmodule

// File: tb/tb_class_argmax_collector.sv
// Directed bench: three collectors (signed/low-tie, signed/high-tie, unsigned)
// share one stimulus stream; frame vectors are table-driven plus corner sequences.
module tb_class_argmax_collector;

    localparam int DW = 32;
    localparam int NC = 10;
    localparam int IW = 4;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           clk_en = 1'b1;
    logic [DW-1:0]  i_data = '0;
    logic           i_valid = 1'b0;
    logic           i_sop = 1'b0;
    logic           i_eop = 1'b0;
    logic           o_ready = 1'b1;

    logic           i_ready0, i_ready1, i_ready2;
    logic           o_valid0, o_valid1, o_valid2;
    logic [NC*DW-1:0] cls0, cls1, cls2;
    logic [IW-1:0]  am0, am1, am2;
    logic [DW-1:0]  mx0, mx1, mx2;
    logic           el0, el1, el2;
    logic           es0, es1, es2;

    always #5 clk = ~clk;

    class_argmax_collector #(.DATA_WIDTH(DW), .CLASSES_QNT(NC), .SIGNED(1), .TIE_LOW(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(i_data), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop), .i_ready(i_ready0), .o_valid(o_valid0), .o_ready(o_ready),
        .o_classes(cls0), .o_argmax(am0), .o_max(mx0), .o_err_len(el0), .o_err_sop(es0));

    class_argmax_collector #(.DATA_WIDTH(DW), .CLASSES_QNT(NC), .SIGNED(1), .TIE_LOW(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(i_data), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop), .i_ready(i_ready1), .o_valid(o_valid1), .o_ready(o_ready),
        .o_classes(cls1), .o_argmax(am1), .o_max(mx1), .o_err_len(el1), .o_err_sop(es1));

    class_argmax_collector #(.DATA_WIDTH(DW), .CLASSES_QNT(NC), .SIGNED(0), .TIE_LOW(1)) dut2 (
        .clk(clk), .rst_n(rst_n), .clk_en(clk_en), .i_data(i_data), .i_valid(i_valid),
        .i_sop(i_sop), .i_eop(i_eop), .i_ready(i_ready2), .o_valid(o_valid2), .o_ready(o_ready),
        .o_classes(cls2), .o_argmax(am2), .o_max(mx2), .o_err_len(el2), .o_err_sop(es2));

    typedef struct {
        int n;
        bit stray;
        int sc [12];
        int a0, a1, a2;
        int m0, m2;
        bit el, es;
    } vec_t;

    vec_t vt [8];
    int   cur [12];
    int   nom [10] = '{3, -5, 7, 2, 7, 0, 1, 1, 1, 1};
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string nm, input logic [NC*DW-1:0] act, input logic [NC*DW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            $display("[TB] ok   %s = %0h", nm, act);
        end
    endtask

    function automatic logic [NC*DW-1:0] z32(input logic [31:0] v);
        return {{(NC*DW-32){1'b0}}, v};
    endfunction

    function automatic logic [NC*DW-1:0] exp_classes(input int n);
        logic [NC*DW-1:0] e;
        e = '0;
        for (int i = 0; i < NC; i++) begin
            if (i < n) e[i*DW +: DW] = 32'(cur[i]);
        end
        return e;
    endfunction

    // Called #1 after a clock edge; returns #1 after the edge that took the last beat.
    task automatic send(input int n, input int stall_at, input bit do_eop);
        for (int k = 0; k < n; k++) begin
            int w = 0;
            while (!i_ready0 && w < 20) begin
                @(posedge clk); #1;
                w++;
            end
            if (!i_ready0) begin
                tests++;
                fails++;
                $display("FAIL ready_wait: got i_ready=0 expected 1 within 20 cycles");
            end
            i_valid = 1'b1;
            i_data  = 32'(cur[k]);
            i_sop   = (k == 0);
            i_eop   = do_eop && (k == n - 1);
            if (k == stall_at) begin
                clk_en = 1'b0;
                repeat (5) @(posedge clk);
                #1;
                clk_en = 1'b1;
            end
            @(posedge clk); #1;
        end
        i_valid = 1'b0;
        i_sop   = 1'b0;
        i_eop   = 1'b0;
    endtask

    task automatic load_nom();
        for (int k = 0; k < 12; k++) cur[k] = (k < 10) ? nom[k] : 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int r = 0; r < 8; r++) begin
            vt[r].sc = '{default: 0};
            vt[r].stray = 0;
            vt[r].el = 0;
            vt[r].es = 0;
        end
        for (int k = 0; k < 10; k++) begin
            vt[0].sc[k] = nom[k];
            vt[2].sc[k] = nom[k];
            vt[3].sc[k] = nom[k];
            vt[5].sc[k] = 10 * (k + 1);
            vt[7].sc[k] = 5;
        end
        vt[0].n = 10; vt[0].a0 = 2; vt[0].a1 = 4; vt[0].a2 = 1; vt[0].m0 = 7; vt[0].m2 = -5;
        vt[1].sc[0] = 5; vt[1].sc[1] = -1; vt[1].sc[2] = 3;
        vt[1].n = 10; vt[1].a0 = 0; vt[1].a1 = 0; vt[1].a2 = 1; vt[1].m0 = 5; vt[1].m2 = -1;
        vt[2] = vt[0]; vt[2].stray = 1; vt[2].es = 1;
        vt[3] = vt[0];
        vt[4].sc[0] = 1; vt[4].sc[1] = 2; vt[4].sc[2] = 3; vt[4].sc[3] = 9;
        vt[4].sc[4] = 4; vt[4].sc[5] = 5; vt[4].sc[6] = 6;
        vt[4].n = 7; vt[4].a0 = 3; vt[4].a1 = 3; vt[4].a2 = 3; vt[4].m0 = 9; vt[4].m2 = 9; vt[4].el = 1;
        vt[5].sc[10] = 500; vt[5].sc[11] = 600;
        vt[5].n = 12; vt[5].a0 = 9; vt[5].a1 = 9; vt[5].a2 = 9; vt[5].m0 = 100; vt[5].m2 = 100; vt[5].el = 1;
        vt[6].sc[0] = 42;
        vt[6].n = 1; vt[6].a0 = 0; vt[6].a1 = 0; vt[6].a2 = 0; vt[6].m0 = 42; vt[6].m2 = 42; vt[6].el = 1;
        vt[7].n = 10; vt[7].a0 = 0; vt[7].a1 = 9; vt[7].a2 = 0; vt[7].m0 = 5; vt[7].m2 = 5;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_valid", z32(32'(o_valid0)), z32(0));
        chk("rst_ready", z32(32'(i_ready0)), z32(1));
        chk("rst_classes", cls0, '0);
        chk("rst_argmax_max", z32({mx0[27:0], am0}), z32(0));
        chk("rst_err", z32({30'd0, el0, es0}), z32(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Table-driven frames, o_ready held high
        for (int r = 0; r < 8; r++) begin
            for (int k = 0; k < 12; k++) cur[k] = vt[r].sc[k];
            if (vt[r].stray) begin
                i_valid = 1'b1; i_data = 32'd999; i_sop = 1'b0; i_eop = 1'b0;
                @(posedge clk); #1;
                i_valid = 1'b0;
            end
            send(vt[r].n, -1, 1);
            chk($sformatf("v%0d_valid", r), z32(32'(o_valid0)), z32(1));
            chk($sformatf("v%0d_argmax_s_low", r), z32(32'(am0)), z32(32'(vt[r].a0)));
            chk($sformatf("v%0d_argmax_s_high", r), z32(32'(am1)), z32(32'(vt[r].a1)));
            chk($sformatf("v%0d_argmax_uns", r), z32(32'(am2)), z32(32'(vt[r].a2)));
            chk($sformatf("v%0d_max_s", r), z32(mx0), z32(32'(vt[r].m0)));
            chk($sformatf("v%0d_max_uns", r), z32(mx2), z32(32'(vt[r].m2)));
            chk($sformatf("v%0d_err_len", r), z32(32'(el0)), z32(32'(vt[r].el)));
            chk($sformatf("v%0d_err_sop", r), z32(32'(es0)), z32(32'(vt[r].es)));
            chk($sformatf("v%0d_classes", r), cls0, exp_classes(vt[r].n));
            @(posedge clk); #1;
            chk($sformatf("v%0d_valid_drop", r), z32(32'(o_valid0)), z32(0));
        end

        // Backpressure: A lands in the output register, B waits in PEND
        o_ready = 1'b0;
        load_nom();
        send(10, -1, 1);
        chk("bp_a_valid", z32(32'(o_valid0)), z32(1));
        cur = '{5, -1, 3, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        send(10, -1, 1);
        chk("bp_ready_low", z32(32'(i_ready0)), z32(0));
        chk("bp_hold_max", z32(mx0), z32(7));
        repeat (2) @(posedge clk);
        #1;
        chk("bp_hold_argmax", z32(32'(am0)), z32(2));
        chk("bp_hold_valid", z32(32'(o_valid0)), z32(1));
        o_ready = 1'b1;
        @(posedge clk); #1;
        o_ready = 1'b0;
        chk("bp_b_valid", z32(32'(o_valid0)), z32(1));
        chk("bp_b_max", z32(mx0), z32(5));
        chk("bp_b_argmax", z32(32'(am0)), z32(0));
        chk("bp_ready_high", z32(32'(i_ready0)), z32(1));
        chk("bp_b_classes", cls0, exp_classes(10));

        // Asynchronous reset mid-frame while B is still held
        cur = '{50, 50, 50, 50, 50, 0, 0, 0, 0, 0, 0, 0};
        send(5, -1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mrst_valid", z32(32'(o_valid0)), z32(0));
        chk("mrst_classes", cls0, '0);
        chk("mrst_max", z32(mx0), z32(0));
        chk("mrst_ready", z32(32'(i_ready0)), z32(1));
        @(posedge clk); #1;
        rst_n = 1'b1;
        o_ready = 1'b1;
        @(posedge clk); #1;
        load_nom();
        send(10, -1, 1);
        chk("mrst_post_argmax", z32(32'(am0)), z32(2));
        chk("mrst_post_err", z32({30'd0, el0, es0}), z32(0));
        chk("mrst_post_classes", cls0, exp_classes(10));
        @(posedge clk); #1;

        // Restart: sop after 4 beats of an open frame
        cur = '{100, 100, 100, 100, 0, 0, 0, 0, 0, 0, 0, 0};
        send(4, -1, 0);
        chk("rs_no_emit", z32(32'(o_valid0)), z32(0));
        load_nom();
        send(10, -1, 1);
        chk("rs_valid", z32(32'(o_valid0)), z32(1));
        chk("rs_err_sop", z32(32'(es0)), z32(1));
        chk("rs_err_len", z32(32'(el0)), z32(0));
        chk("rs_max", z32(mx0), z32(7));
        chk("rs_classes", cls0, exp_classes(10));
        @(posedge clk); #1;
        chk("rs_single", z32(32'(o_valid0)), z32(0));

        // Clock-enable stall of 5 cycles on beat 4
        load_nom();
        send(10, 4, 1);
        chk("ce_valid", z32(32'(o_valid0)), z32(1));
        chk("ce_argmax", z32(32'(am0)), z32(2));
        chk("ce_max", z32(mx0), z32(7));
        chk("ce_err", z32({30'd0, el0, es0}), z32(0));
        chk("ce_classes", cls0, exp_classes(10));
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
